// File: rtl/loader_pkg.sv
// Shared definitions for the serial-to-block-RAM frame loader:
// default geometry, frame start marker and FSM state encoding.
package loader_pkg;

    localparam int         DEF_RAM_WIDTH     = 16;
    localparam int         DEF_RAM_ADDR_BITS = 14;
    localparam logic [7:0] DEF_SYNC_BYTE     = 8'hA5;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR_HI = 4'd1,
        ADDR_LO = 4'd2,
        CNT_HI  = 4'd3,
        CNT_LO  = 4'd4,
        DATA_HI = 4'd5,
        DATA_LO = 4'd6,
        WRITE   = 4'd7,
        CHECK   = 4'd8
    } state_e;

    // All multi-byte fields on the wire are big-endian.
    function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/ram_loader.sv
// Frame loader: parses SYNC / address / count / data words / checksum from a
// byte stream and writes the data words into a block RAM while the CPU is held.
module ram_loader
    import loader_pkg::*;
#(
    parameter int         RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int         RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     ram_en,
    output logic                     ram_wr_en,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_data,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic                     load_err
);

    state_e                   state_q, state_d;
    logic [7:0]               hi_q, hi_d;
    logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [7:0]               csum_q, csum_d;
    logic [RAM_WIDTH-1:0]     word_q, word_d;
    logic                     cpu_hold_q, cpu_hold_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     accept;

    assign rx_ready = (state_q != WRITE);
    assign accept   = rx_valid && rx_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        word_d     = word_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d    = ADDR_HI;
                    cpu_hold_d = 1'b1;
                    csum_d     = 8'h00;
                end
            end
            ADDR_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (accept) begin
                    // Address bits above RAM_ADDR_BITS are dropped by the cast.
                    addr_d  = RAM_ADDR_BITS'(be16(hi_q, rx_data));
                    state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    cnt_d   = be16(hi_q, rx_data);
                    state_d = (be16(hi_q, rx_data) == 16'h0000) ? CHECK : DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    word_d  = RAM_WIDTH'(be16(hi_q, rx_data));
                    csum_d  = csum_q ^ rx_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + RAM_ADDR_BITS'(1);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (accept) begin
                    done_d     = (rx_data == csum_q);
                    err_d      = (rx_data != csum_q);
                    cpu_hold_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                cpu_hold_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments and all clear on async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ram_en    = (state_q == WRITE);
    assign ram_wr_en = (state_q == WRITE);
    assign ram_addr  = addr_q;
    assign ram_data  = word_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: table of whole frames with expected
// RAM writes and end-of-frame pulse, plus stall and mid-frame reset sequences.
module tb_ram_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        ram_en;
    logic        ram_wr_en;
    logic [13:0] ram_addr;
    logic [15:0] ram_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    ram_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .ram_en    (ram_en),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] a;
        logic [15:0] d;
    } wr_t;

    // Up to 12 frame bytes, first byte in the top 8 bits.
    typedef struct packed {
        logic [95:0]      b;
        logic [3:0]       n;
        logic [1:0]       nwr;
        logic [1:0][13:0] wa;
        logic [1:0][15:0] wd;
        logic             done;
        logic             err;
    } frame_t;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    wr_t         wr_q[$];
    logic [15:0] mem [int];
    frame_t      vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write/pulse monitor; the loader must never accept a byte during a RAM write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wr_en) begin
                wr_q.push_back('{a: ram_addr, d: ram_data});
                mem[int'(ram_addr)] = ram_data;
                check("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
                check("en_with_wr_en", {31'd0, ram_en}, 32'd1);
            end
            if (load_done) done_cnt++;
            if (load_err)  err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait actual=0 required=1 after %0d cycles", waited);
        end
        @(posedge clk);
    endtask

    task automatic finish_frame(input string tag, input logic exp_done, input logic exp_err);
        @(negedge clk);
        rx_valid = 1'b0;
        check({tag, "_hold_end"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'd0, load_done, load_err}, 32'd0);
        check({tag, "_done_cnt"}, done_cnt, {31'd0, exp_done});
        check({tag, "_err_cnt"}, err_cnt, {31'd0, exp_err});
    endtask

    task automatic clear_scoreboard();
        wr_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bt;

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst_n    = 1'b0;

        // Checksum of 12 34 AB CD is 40; 9E and 00 are both wrong checksums.
        vec[0] = '{b: {8'hA5,8'h00,8'h10,8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40,8'h00,8'h00},
                   n: 4'd10, nwr: 2'd2, wa: {14'h0011, 14'h0010}, wd: {16'hABCD, 16'h1234},
                   done: 1'b1, err: 1'b0};
        vec[1] = '{b: {8'hA5,8'h00,8'h10,8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h00,8'h00,8'h00},
                   n: 4'd10, nwr: 2'd2, wa: {14'h0011, 14'h0010}, wd: {16'hABCD, 16'h1234},
                   done: 1'b0, err: 1'b1};
        vec[2] = '{b: {8'hA5,8'h00,8'h10,8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h9E,8'h00,8'h00},
                   n: 4'd10, nwr: 2'd2, wa: {14'h0011, 14'h0010}, wd: {16'hABCD, 16'h1234},
                   done: 1'b0, err: 1'b1};
        vec[3] = '{b: {8'hA5,8'h3F,8'hFF,8'h00,8'h02,8'h00,8'h01,8'h00,8'h02,8'h03,8'h00,8'h00},
                   n: 4'd10, nwr: 2'd2, wa: {14'h0000, 14'h3FFF}, wd: {16'h0002, 16'h0001},
                   done: 1'b1, err: 1'b0};
        vec[4] = '{b: {8'h11,8'h22,8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                   n: 4'd8, nwr: 2'd0, wa: '0, wd: '0, done: 1'b1, err: 1'b0};
        // Address FFF0 truncates to 3FF0; BE ^ EF = 51.
        vec[5] = '{b: {8'hA5,8'hFF,8'hF0,8'h00,8'h01,8'hBE,8'hEF,8'h51,8'h00,8'h00,8'h00,8'h00},
                   n: 4'd8, nwr: 2'd1, wa: {14'h0000, 14'h3FF0}, wd: {16'h0000, 16'hBEEF},
                   done: 1'b1, err: 1'b0};

        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_ram_en", {30'd0, ram_en, ram_wr_en}, 32'd0);
        check("rst_pulses", {30'd0, load_done, load_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            clear_scoreboard();
            for (int i = 0; i < int'(vec[k].n) - 1; i++) begin
                bt = vec[k].b[95 - 8*i -: 8];
                send_byte(bt);
            end
            #1;
            check($sformatf("v%0d_hold_mid", k), {31'd0, cpu_hold}, 32'd1);
            bt = vec[k].b[95 - 8*(int'(vec[k].n) - 1) -: 8];
            send_byte(bt);
            finish_frame($sformatf("v%0d", k), vec[k].done, vec[k].err);
            check($sformatf("v%0d_nwr", k), wr_q.size(), {30'd0, vec[k].nwr});
            for (int j = 0; j < int'(vec[k].nwr); j++) begin
                if (j < wr_q.size()) begin
                    check($sformatf("v%0d_wr%0d_addr", k, j), {18'd0, wr_q[j].a}, {18'd0, vec[k].wa[j]});
                    check($sformatf("v%0d_wr%0d_data", k, j), {16'd0, wr_q[j].d}, {16'd0, vec[k].wd[j]});
                end
            end
        end

        // Stalled sender: loader waits in ADDR_LO with the CPU held.
        clear_scoreboard();
        send_byte(8'hA5);
        send_byte(8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_hold", {31'd0, cpu_hold}, 32'd1);
        check("stall_ready", {31'd0, rx_ready}, 32'd1);
        check("stall_no_write", wr_q.size(), 32'd0);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h26);
        finish_frame("stall", 1'b1, 1'b0);
        check("stall_nwr", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) begin
            check("stall_addr", {18'd0, wr_q[0].a}, 32'h0020);
            check("stall_data", {16'd0, wr_q[0].d}, 32'h1234);
        end

        // Reset after DATA_HI of the second word; the first word stays written.
        clear_scoreboard();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mrst_hold", {31'd0, cpu_hold}, 32'd0);
        check("mrst_ready", {31'd0, rx_ready}, 32'd1);
        check("mrst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_no_pulses", done_cnt + err_cnt, 32'd0);
        check("mrst_nwr", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) begin
            check("mrst_addr", {18'd0, wr_q[0].a}, 32'h0100);
            check("mrst_data", {16'd0, wr_q[0].d}, 32'h1122);
        end

        clear_scoreboard();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h33);
        finish_frame("after_rst", 1'b1, 1'b0);
        check("after_rst_nwr", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) begin
            check("after_rst_addr", {18'd0, wr_q[0].a}, 32'h0005);
            check("after_rst_data", {16'd0, wr_q[0].d}, 32'h5566);
        end
        check("mem_0100_intact", {16'd0, mem.exists(32'h100) ? mem[32'h100] : 16'hxxxx}, 32'h1122);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
